// File: rtl/stream_fifo.sv
// stream_fifo: synchronous valid/ready FIFO with first-word-fall-through output.
// The payload store is an inferred RAM array with a registered read into the
// output register. A word pushed while nothing is waiting in the RAM bypasses
// the RAM and lands straight in the output register, so data is visible one
// cycle after the push. The occupancy count includes the output register.
// Optional build macro: STREAM_FIFO_PEAK_EN enables the peak-occupancy tracker.
module stream_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 1024,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  flush,
   input  logic [CW-1:0]         af_thresh,
   input  logic [CW-1:0]         ae_thresh,
   output logic [CW-1:0]         count,
   output logic                  almost_full,
   output logic                  almost_empty,
   input  logic                  peak_clr,
   output logic [CW-1:0]         peak_level
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Payload storage; never reset.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]         count_reg, count_next;
   logic                  out_valid_reg, out_valid_next;
   logic [DATA_WIDTH-1:0] out_data_reg;

   logic push;
   logic pop;
   logic mem_empty;
   logic out_free;
   logic mem_we;
   logic out_load;
   logic out_from_mem;

   // Handshakes and status flags are derived from registered state only.
   assign s_ready      = (count_reg != DEPTH_C);
   assign m_valid      = out_valid_reg;
   assign m_data       = out_data_reg;
   assign count        = count_reg;
   assign almost_full  = (count_reg >= af_thresh);
   assign almost_empty = (count_reg <= ae_thresh);

   assign push = s_valid && s_ready;
   assign pop  = out_valid_reg && m_ready;

   // The RAM never holds more than DEPTH-1 words (one word always sits in the
   // output register once anything is stored), so equal pointers mean empty
   // and a read never collides with a same-cycle write.
   assign mem_empty = (rd_ptr_reg == wr_ptr_reg);

   // The output register can take a new word when it is empty or being popped.
   assign out_free = !out_valid_reg || pop;

   // Next-state decode: output register refill, RAM write, pointer and count updates.
   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      out_valid_next = out_valid_reg;
      mem_we         = 1'b0;
      out_load       = 1'b0;
      out_from_mem   = 1'b0;

      if (flush) begin
         // Flush wins: any push or pop this cycle is dropped.
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         count_next     = '0;
         out_valid_next = 1'b0;
      end else begin
         if (out_free) begin
            if (!mem_empty) begin
               // Oldest RAM word moves into the output register.
               out_load       = 1'b1;
               out_from_mem   = 1'b1;
               rd_ptr_next    = rd_ptr_reg + AW'(1);
               out_valid_next = 1'b1;
               mem_we         = push;
            end else if (push) begin
               // Nothing queued behind the output: incoming word bypasses the RAM.
               out_load       = 1'b1;
               out_valid_next = 1'b1;
            end else begin
               out_valid_next = 1'b0;
            end
         end else begin
            mem_we = push;
         end

         if (mem_we) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
         end

         case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // RAM write port.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_reg] <= s_data;
      end
   end

   // Output register: registered RAM read or direct bypass of the pushed word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg <= '0;
      end else if (out_load) begin
         out_data_reg <= out_from_mem ? mem[rd_ptr_reg] : s_data;
      end
   end

`ifdef STREAM_FIFO_PEAK_EN
   logic [CW-1:0] peak_reg;

   // Peak tracker follows the next count; flush leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_reg <= '0;
      end else if (peak_clr) begin
         peak_reg <= count_next;
      end else if (count_next > peak_reg) begin
         peak_reg <= count_next;
      end
   end

   assign peak_level = peak_reg;
`else
   logic unused_peak_clr;

   assign unused_peak_clr = peak_clr;
   assign peak_level      = '0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed bench for stream_fifo (DEPTH=8) with a queue
// scoreboard; expected words are queued on accepted pushes and compared on pops.
module tb_stream_fifo;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          flush;
   logic [CW-1:0] af_thresh;
   logic [CW-1:0] ae_thresh;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          almost_empty;
   logic          peak_clr;
   logic [CW-1:0] peak_level;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] sb [$];

   stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .flush        (flush),
      .af_thresh    (af_thresh),
      .ae_thresh    (ae_thresh),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .peak_clr     (peak_clr),
      .peak_level   (peak_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // One clock: resolve handshakes against the scoreboard, then advance to 1ns past the edge.
   task automatic tick();
      logic [DW-1:0] exp_data;
      #1;
      if (flush) begin
         $display("t=%0t flush (dropped %0d queued words)", $time, sb.size());
         sb.delete();
      end else begin
         if (m_valid && m_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL sb_underflow observed=pop expected=no_pop data=0x%0h", m_data);
            end
            if (sb.size() != 0) begin
               exp_data = sb.pop_front();
               $display("t=%0t pop  data=0x%04h expect=0x%04h", $time, m_data, exp_data);
               chk("m_data", {16'h0, m_data}, {16'h0, exp_data});
            end
         end
         if (s_valid && s_ready) begin
            sb.push_back(s_data);
            $display("t=%0t push data=0x%04h", $time, s_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      m_ready   = 1'b0;
      flush     = 1'b0;
      af_thresh = CW'(6);
      ae_thresh = CW'(1);
      peak_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_count", count, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_almost_full", almost_full, 0);
      chk("rst_almost_empty", almost_empty, 1);
      chk("rst_peak", peak_level, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full with the consumer stalled
      for (int i = 1; i <= 8; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(i);
         chk("fill_s_ready", s_ready, 1);
         tick();
         chk("fill_count", count, i);
         chk("fill_af", almost_full, (i >= 6) ? 1 : 0);
      end
      s_data = 16'h0009;
      chk("full_s_ready", s_ready, 0);
      chk("full_af", almost_full, 1);
      tick();
      chk("full_no_accept", count, 8);
      s_valid = 1'b0;

      // Drain all eight in order, one per cycle
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("drain_count", count, 7 - i);
         chk("drain_m_valid", m_valid, (i < 7) ? 1 : 0);
         chk("drain_ae", almost_empty, ((7 - i) <= 1) ? 1 : 0);
         if (i == 0) chk("drain_s_ready_after_full", s_ready, 1);
      end
      m_ready = 1'b0;

      // FWFT latency into an empty FIFO
      s_valid = 1'b1;
      s_data  = 16'hABCD;
      tick();
      s_valid = 1'b0;
      chk("fwft_m_valid", m_valid, 1);
      chk("fwft_m_data", m_data, 16'hABCD);
      chk("fwft_count", count, 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("fwft_drained", count, 0);

      // Steady push+pop at count=4 across pointer wrap
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(16'h0100 + i);
         tick();
      end
      chk("steady_start", count, 4);
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_data = DW'(16'h0200 + i);
         tick();
         chk("steady_count", count, 4);
      end
      m_ready = 1'b0;
      s_data  = 16'h0300;
      tick();
      chk("pre_flush_count", count, 5);

      // Flush with a concurrent push and pop
      flush   = 1'b1;
      s_data  = 16'hDEAD;
      m_ready = 1'b1;
      tick();
      flush   = 1'b0;
      s_valid = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_m_valid", m_valid, 0);
      chk("flush_s_ready", s_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_stays_empty", m_valid, 0);
      end
      m_ready = 1'b0;

      // Simultaneous push and pop at count=1 reloads the output register
      s_valid = 1'b1;
      s_data  = 16'h1111;
      tick();
      s_data  = 16'h2222;
      m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("reload_count", count, 1);
      chk("reload_m_valid", m_valid, 1);
      chk("reload_m_data", m_data, 16'h2222);
      tick();
      m_ready = 1'b0;
      chk("reload_drained", count, 0);

      // Runtime thresholds
      af_thresh = '0;
      #1;
      chk("af_zero_forces", almost_full, 1);
      af_thresh = CW'(6);
      ae_thresh = '0;
      s_valid   = 1'b1;
      s_data    = 16'h3333;
      tick();
      s_valid = 1'b0;
      chk("ae_zero_count1", almost_empty, 0);
      ae_thresh = CW'(1);
      #1;
      chk("ae_one_count1", almost_empty, 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;

`ifdef STREAM_FIFO_PEAK_EN
      // Peak tracker
      peak_clr = 1'b1;
      tick();
      peak_clr = 1'b0;
      chk("peak_clr_empty", peak_level, 0);
      s_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_data = DW'(16'h0400 + i);
         tick();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (4) tick();
      m_ready = 1'b0;
      chk("peak_count2", count, 2);
      chk("peak_6", peak_level, 6);
      peak_clr = 1'b1;
      tick();
      peak_clr = 1'b0;
      chk("peak_after_clr", peak_level, 2);
      s_valid = 1'b1;
      s_data  = 16'h0500;
      tick();
      s_valid = 1'b0;
      chk("peak_3", peak_level, 3);
      m_ready = 1'b1;
      repeat (3) tick();
      m_ready = 1'b0;
`else
      chk("peak_disabled", peak_level, 0);
`endif

      chk("final_count", count, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
